// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and bus widths for the pipelined Wishbone core master
package wb_pkg;
   localparam int WB_AW   = 32;
   localparam int WB_DW   = 32;
   localparam int WB_SELW = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } wb_mst_state_e;
endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - pipelined Wishbone bus bundle with initiator/target modports
interface wishbone_if;
   import wb_pkg::*;

   logic               cyc;
   logic               stb;
   logic               we;
   logic [WB_AW-1:0]   addr;
   logic [WB_DW-1:0]   data_m;
   logic [WB_DW-1:0]   data_s;
   logic [WB_SELW-1:0] sel;
   logic               ack;
   logic               err;
   logic               stall;

   modport master (
      output cyc, stb, addr, data_m, we, sel,
      input  data_s, ack, err, stall
   );

   modport slave (
      input  cyc, stb, addr, data_m, we, sel,
      output data_s, ack, err, stall
   );
endinterface

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - idle-cycle counter that flags the cycle in which LIMIT idle cycles complete
module wb_watchdog #(
   parameter int LIMIT = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_clear,
   output logic o_expired
);
   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_count;

   // Expiry fires during the LIMIT-th uncleared cycle so the abort follows immediately.
   assign o_expired = ~i_clear & (r_count == CW'(LIMIT - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (!o_expired) begin
         r_count <= r_count + CW'(1);
      end
   end
endmodule

// File: rtl/wb_core_master.sv
// rtl/wb_core_master.sv - core req/gnt to pipelined Wishbone initiator; WB_MASTER_TIMEOUT_EN adds watchdog abort
module wb_core_master
   import wb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_i,
   output logic               gnt_o,
   input  logic [WB_AW-1:0]   addr_i,
   input  logic               we_i,
   input  logic [WB_SELW-1:0] be_i,
   input  logic [WB_DW-1:0]   wdata_i,
   output logic               rvalid_o,
   output logic [WB_DW-1:0]   rdata_o,
   output logic               err_o,
   wishbone_if.master         wb
);
   wb_mst_state_e r_state, w_next_state;
   logic [2:0]    r_outstanding, w_outstanding_nxt;
   logic          w_room, w_abort, w_pending, w_bus_resp, w_timeout;
   logic          w_stb, w_gnt, w_cyc, w_rvalid, w_err;

   assign w_pending  = (r_outstanding != 3'd0);
   assign w_room     = (r_outstanding < 3'(MAX_OUTSTANDING));
   assign w_abort    = (r_state == ABORT);
   // Responses with nothing outstanding, or arriving during abort, are dropped.
   assign w_bus_resp = (wb.ack | wb.err) & w_pending & ~w_abort;

   assign wb.addr   = addr_i;
   assign wb.data_m = wdata_i;
   assign wb.we     = we_i;
   assign wb.sel    = be_i;
   assign wb.stb    = w_stb;
   assign wb.cyc    = w_cyc;
   assign gnt_o     = w_gnt;
   assign rvalid_o  = w_rvalid;
   assign err_o     = w_err;
   assign rdata_o   = wb.data_s;

   always_comb begin
      w_stb    = rst_ni & req_i & w_room & ~w_abort;
      w_gnt    = w_stb & ~wb.stall;
      w_cyc    = (w_stb | w_pending) & ~w_abort;
      w_rvalid = w_bus_resp | (w_abort & w_pending);
      w_err    = w_abort ? w_pending : (w_bus_resp & wb.err);
   end

   always_comb begin
      w_outstanding_nxt = r_outstanding;
      case ({w_gnt, w_rvalid})
         2'b10:   w_outstanding_nxt = r_outstanding + 3'd1;
         2'b01:   w_outstanding_nxt = r_outstanding - 3'd1;
         default: w_outstanding_nxt = r_outstanding;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_outstanding <= 3'd0;
      end else begin
         r_outstanding <= w_outstanding_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_gnt) w_next_state = BUSY;
         BUSY: begin
            if (w_timeout) begin
               w_next_state = ABORT;
            end else if ((w_outstanding_nxt == 3'd0) && !w_gnt) begin
               w_next_state = IDLE;
            end
         end
         ABORT:   if (w_outstanding_nxt == 3'd0) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

`ifdef WB_MASTER_TIMEOUT_EN
   wb_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .i_clear   (w_gnt | w_rvalid | (r_state != BUSY)),
      .o_expired (w_timeout)
   );
`else
   logic w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign w_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_wb_core_master.sv
// tb/tb_wb_core_master.sv - directed scoreboard bench for wb_core_master (timeout steps under WB_MASTER_TIMEOUT_EN)
module tb_wb_core_master;
   import wb_pkg::*;

   localparam logic [31:0] MAGIC = 32'hCAFE_0000;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        err;
   } slv_t;

   logic        clk_i, rst_ni, req_i, gnt_o, we_i, rvalid_o, err_o;
   logic [31:0] addr_i, wdata_i, rdata_o;
   logic [3:0]  be_i;

   wishbone_if wb();

   wb_core_master #(
      .MAX_OUTSTANDING (2),
      .TIMEOUT_CYCLES  (8)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_i    (req_i),
      .gnt_o    (gnt_o),
      .addr_i   (addr_i),
      .we_i     (we_i),
      .be_i     (be_i),
      .wdata_i  (wdata_i),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o),
      .wb       (wb)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   slv_t slv_q[$];
   logic slv_err_next = 1'b0;
   logic abort_exp    = 1'b0;
   logic s_gnt, s_stb, s_cyc, s_rvalid, s_err, s_we;
   logic [31:0] s_addr, s_data_m;
   logic [3:0]  s_sel;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // resp: 0 = none, 1 = answer oldest pending transfer, 2 = spurious ack
   task automatic cycle(input int resp);
      exp_t e;
      logic answered;
      answered   = (resp == 1) && (slv_q.size() > 0);
      wb.ack     = 1'b0;
      wb.err     = 1'b0;
      wb.data_s  = 32'h0;
      if (answered) begin
         wb.ack    = ~slv_q[0].err;
         wb.err    = slv_q[0].err;
         wb.data_s = slv_q[0].addr ^ MAGIC;
      end else if (resp == 2) begin
         wb.ack    = 1'b1;
         wb.data_s = 32'hBAD0_BAD0;
      end
      #1;
      s_gnt = gnt_o; s_stb = wb.stb; s_cyc = wb.cyc; s_rvalid = rvalid_o; s_err = err_o;
      s_we = wb.we; s_addr = wb.addr; s_data_m = wb.data_m; s_sel = wb.sel;
      if (gnt_o) begin
         slv_q.push_back('{addr_i, slv_err_next});
         exp_q.push_back('{addr_i ^ MAGIC, slv_err_next});
      end
      if (rvalid_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rvalid", 32'(rvalid_o), 32'd0);
         end else begin
            e = exp_q.pop_front();
            if (abort_exp) e.err = 1'b1;
            chk("resp_err", 32'(err_o), 32'(e.err));
            if (!e.err) chk("resp_data", rdata_o, e.data);
         end
      end
      if (answered) void'(slv_q.pop_front());
      @(posedge clk_i);
      #1;
      wb.ack = 1'b0;
      wb.err = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0; req_i = 1'b1; addr_i = 32'h100; we_i = 1'b0; be_i = 4'hF; wdata_i = 32'h0;
      wb.ack = 1'b1; wb.err = 1'b0; wb.stall = 1'b0; wb.data_s = 32'h0;
      @(posedge clk_i); #2;
      chk("rst_cyc", 32'(wb.cyc), 32'd0);
      chk("rst_stb", 32'(wb.stb), 32'd0);
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_rvalid", 32'(rvalid_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      req_i = 1'b0; wb.ack = 1'b0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // single read at 0x100
      req_i = 1'b1; addr_i = 32'h100;
      cycle(0);
      chk("rd1_gnt", 32'(s_gnt), 32'd1);
      chk("rd1_addr", s_addr, 32'h100);
      chk("rd1_we", 32'(s_we), 32'd0);
      req_i = 1'b0;
      cycle(1);
      chk("rd1_rvalid", 32'(s_rvalid), 32'd1);
      cycle(0);
      chk("rd1_cyc_low", 32'(s_cyc), 32'd0);

      // three back-to-back reads, two outstanding max
      req_i = 1'b1; addr_i = 32'h200; cycle(0);
      chk("b2b_gnt0", 32'(s_gnt), 32'd1);
      addr_i = 32'h204; cycle(0);
      chk("b2b_gnt1", 32'(s_gnt), 32'd1);
      addr_i = 32'h208; cycle(0);
      chk("b2b_full_gnt", 32'(s_gnt), 32'd0);
      chk("b2b_full_stb", 32'(s_stb), 32'd0);
      cycle(1);
      chk("b2b_ack0_gnt", 32'(s_gnt), 32'd0);
      chk("b2b_ack0_rvalid", 32'(s_rvalid), 32'd1);
      cycle(1);
      chk("b2b_gnt2_with_ack", 32'(s_gnt), 32'd1);
      chk("b2b_ack1_rvalid", 32'(s_rvalid), 32'd1);
      req_i = 1'b0;
      cycle(1);
      chk("b2b_ack2_rvalid", 32'(s_rvalid), 32'd1);
      cycle(0);
      chk("b2b_cyc_low", 32'(s_cyc), 32'd0);

      // stall held for four cycles
      req_i = 1'b1; addr_i = 32'h300; wb.stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(0);
         chk("stall_gnt", 32'(s_gnt), 32'd0);
         chk("stall_stb", 32'(s_stb), 32'd1);
         chk("stall_addr", s_addr, 32'h300);
      end
      wb.stall = 1'b0;
      cycle(0);
      chk("stall_release_gnt", 32'(s_gnt), 32'd1);
      req_i = 1'b0;
      cycle(1);
      chk("stall_rvalid", 32'(s_rvalid), 32'd1);

      // partial write answered with err
      slv_err_next = 1'b1;
      req_i = 1'b1; we_i = 1'b1; be_i = 4'b0011; addr_i = 32'h400; wdata_i = 32'hDEAD_BEEF;
      cycle(0);
      chk("wr_gnt", 32'(s_gnt), 32'd1);
      chk("wr_sel", 32'(s_sel), 32'h3);
      chk("wr_we", 32'(s_we), 32'd1);
      chk("wr_data", s_data_m, 32'hDEAD_BEEF);
      req_i = 1'b0; we_i = 1'b0; be_i = 4'hF; slv_err_next = 1'b0;
      cycle(1);
      chk("wr_rvalid", 32'(s_rvalid), 32'd1);
      chk("wr_err", 32'(s_err), 32'd1);
      cycle(0);
      chk("wr_cyc_low", 32'(s_cyc), 32'd0);

      // spurious ack with nothing outstanding
      cycle(2);
      chk("spur_rvalid", 32'(s_rvalid), 32'd0);
      cycle(0);
      chk("spur_cyc", 32'(s_cyc), 32'd0);
      req_i = 1'b1; addr_i = 32'h500; cycle(0);
      chk("post_spur_gnt", 32'(s_gnt), 32'd1);
      req_i = 1'b0; cycle(1);
      chk("post_spur_rvalid", 32'(s_rvalid), 32'd1);

      // reset while a transfer is outstanding
      req_i = 1'b1; addr_i = 32'h600; cycle(0);
      chk("mid_rst_gnt", 32'(s_gnt), 32'd1);
      req_i = 1'b0; rst_ni = 1'b0; #1;
      chk("mid_rst_cyc", 32'(wb.cyc), 32'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      slv_q.delete(); exp_q.delete();
      cycle(2);
      chk("mid_rst_no_resp", 32'(s_rvalid), 32'd0);
      cycle(0);
      chk("mid_rst_cyc_low", 32'(s_cyc), 32'd0);

`ifdef WB_MASTER_TIMEOUT_EN
      begin
         int  idle;
         bit  dropped;
         idle = 0; dropped = 1'b0;
         req_i = 1'b1; addr_i = 32'h700; cycle(0);
         addr_i = 32'h704; cycle(0);
         req_i = 1'b0; abort_exp = 1'b1;
         for (int i = 0; i < 20 && !dropped; i++) begin
            cycle(0);
            if (s_cyc) idle++;
            else dropped = 1'b1;
         end
         chk("to_dropped", 32'(dropped), 32'd1);
         chk("to_idle_cycles", 32'(idle), 32'd8);
         chk("to_abort_rvalid0", 32'(s_rvalid), 32'd1);
         chk("to_abort_err0", 32'(s_err), 32'd1);
         cycle(2);
         chk("to_abort_rvalid1", 32'(s_rvalid), 32'd1);
         chk("to_abort_err1", 32'(s_err), 32'd1);
         chk("to_abort_cyc", 32'(s_cyc), 32'd0);
         cycle(2);
         chk("to_late_ack_rvalid", 32'(s_rvalid), 32'd0);
         abort_exp = 1'b0; slv_q.delete();
         req_i = 1'b1; addr_i = 32'h800; cycle(0);
         chk("to_idle_gnt", 32'(s_gnt), 32'd1);
         req_i = 1'b0; cycle(1);
         chk("to_idle_rvalid", 32'(s_rvalid), 32'd1);
      end
`endif

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
